mips_boot_loader: RTL and testbench

- Writer side of the instruction-fetch interface: receives a framed program image as a byte stream and writes it word-by-word into instruction memory.
- Holds the single-cycle MIPS core in reset via `cpu_reset` until the image is fully written and its checksum verifies, then releases the core to fetch from BASE_ADDR.
- Replaces testbench-side memory preloading; sits between a byte source (UART receiver or bench driver) and the IMEM write port.

---
 rtl/mips_boot_loader.sv | 149 ++++++++++++++
 tb/tb_mips_boot_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// Byte-stream image loader: parses [LEN_HI LEN_LO data... CSUM] frames and writes words into IMEM.
// Latency: IMEM write strobe 1 cycle after the 4th byte of a word; done/error/cpu_reset on the edge taking the checksum.
// Backpressure: rx_ready is high in LEN_HI/LEN_LO/DATA/CSUM, low in IDLE/DONE/ERR; rx_valid gaps simply stall the parser.
module mips_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;
    logic [23:0] r_word;
    logic        r_rx_ready;
    logic        r_imem_we;
    logic [31:0] r_imem_addr;
    logic [31:0] r_imem_wdata;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_error;

    logic [2:0]  w_next;
    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_len;
    logic        w_word_end;

    assign w_accept   = rx_valid && r_rx_ready;
    assign w_restart  = restart && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_len      = {r_len[15:8], rx_data};
    assign w_word_end = (r_byte_idx == 2'd3);

    // Next-state decode: every transition out of a receive state is gated by an accepted byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len == 16'd0)         w_next = S_CSUM;
                    else if (w_len > MAX_LEN)   w_next = S_ERR;
                    else                        w_next = S_DATA;
                end
            end
            S_DATA:   if (w_accept && w_word_end && (r_idx == r_len - 16'd1)) w_next = S_CSUM;
            S_CSUM:   if (w_accept) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    if (restart) w_next = S_LEN_HI;
            default:  w_next = S_IDLE;
        endcase
    end

    // State and status flags; the flags are registered from the next state so they move on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rx_ready  <= (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                           (w_next == S_DATA)   || (w_next == S_CSUM);
            r_cpu_reset <= (w_next != S_DONE);
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERR);
        end
    end

    // Frame datapath: length capture, running XOR, word assembly and the one-cycle IMEM write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len        <= 16'd0;
            r_idx        <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_csum       <= 8'd0;
            r_word       <= 24'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 32'd0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_restart) begin
                r_idx      <= 16'd0;
                r_byte_idx <= 2'd0;
                r_csum     <= 8'd0;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN_HI: begin
                        r_len[15:8] <= rx_data;
                        r_csum      <= r_csum ^ rx_data;
                    end
                    S_LEN_LO: begin
                        r_len[7:0] <= rx_data;
                        r_csum     <= r_csum ^ rx_data;
                    end
                    S_DATA: begin
                        r_csum     <= r_csum ^ rx_data;
                        r_word     <= {r_word[15:0], rx_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_word_end) begin
                            // Address arithmetic is full 32-bit so a high BASE_ADDR wraps naturally.
                            r_imem_wdata <= {r_word, rx_data};
                            r_imem_addr  <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                            r_imem_we    <= 1'b1;
                            r_idx        <= r_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: directed frames against a frame-level model of expected IMEM writes and outcome.
// Latency: checks sampled on the falling edge or 1 time unit after the rising edge.
// Backpressure: the byte driver holds each byte until it is taken while rx_ready is high.
module tb_mips_boot_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writes as {addr, data}; popped by the compare process.
    logic [63:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_csum;
    logic        prev_we = 1'b0;

    mips_boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: what a correct loader must write and how the frame must end.
    task automatic model_frame(input byte_q_t f);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        n = {f[0], f[1]};
        exp_done = 1'b0;
        exp_err  = 1'b0;
        x = f[0] ^ f[1];
        exp_csum = x;
        if (n > 64) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
            exp_q.push_back({32'(4 * i), w});
            x = x ^ f[2+4*i] ^ f[3+4*i] ^ f[4+4*i] ^ f[5+4*i];
        end
        exp_csum = x;
        if (f[2+4*n] == x) exp_done = 1'b1;
        else               exp_err  = 1'b1;
    endtask

    // Byte driver: holds each byte until accepted, then idles for 'gap' cycles.
    task automatic send_bytes(input byte_q_t b, input int gap);
        bit ok;
        foreach (b[i]) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (rx_ready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            rx_valid = 1'b0;
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_timeout: byte %0d not accepted within budget", i);
                return;
            end
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_end(input string name);
        chk({name, "_done"},      done,      exp_done);
        chk({name, "_error"},     error,     exp_err);
        chk({name, "_cpu_reset"}, cpu_reset, !exp_done);
        chk({name, "_rx_ready"},  rx_ready,  1'b0);
        chk({name, "_missing"},   exp_q.size(), 0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        chk("restart_rx_ready",  rx_ready,  1'b1);
        chk("restart_done",      done,      1'b0);
        chk("restart_error",     error,     1'b0);
        chk("restart_cpu_reset", cpu_reset, 1'b1);
    endtask

    // Compare process: every write must match the model in order, last exactly one cycle,
    // and the core may only run while done is reported.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cpu_reset_vs_done", cpu_reset, !done);
            if (imem_we) begin
                chk("we_width", prev_we, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {imem_addr, imem_wdata}, 64'hx);
                end else begin
                    chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
                end
            end
            prev_we <= imem_we;
        end else begin
            prev_we <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t nom, bad, z_ok, z_bad, big, rs, part;
        nom   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
        bad   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0D};
        z_ok  = '{8'h00, 8'h00, 8'h00};
        z_bad = '{8'h00, 8'h00, 8'h01};
        big   = '{8'h00, 8'h41};
        rs    = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
        part  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};

        rx_data  = 8'h00;
        rx_valid = 1'b0;
        restart  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready",   rx_ready,   1'b0);
        chk("rst_imem_we",    imem_we,    1'b0);
        chk("rst_imem_addr",  imem_addr,  32'h0);
        chk("rst_imem_wdata", imem_wdata, 32'h0);
        chk("rst_cpu_reset",  cpu_reset,  1'b1);
        chk("rst_done",       done,       1'b0);
        chk("rst_error",      error,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_to_len_hi_rx_ready", rx_ready, 1'b1);

        // Pin the model with hand-computed values for the nominal frame.
        model_frame(nom);
        chk("model_w0",   exp_q[0], {32'h0, 32'h2008_0005});
        chk("model_w1",   exp_q[1], {32'h4, 32'h2009_000A});
        chk("model_csum", exp_csum, 8'h0C);
        chk("model_done", exp_done, 1'b1);
        send_bytes(nom, 0);
        check_end("nominal");
        chk("nominal_done_lit", {cpu_reset, done, error}, 3'b010);
        do_restart();

        model_frame(bad);
        send_bytes(bad, 0);
        check_end("bad_csum");
        chk("bad_csum_lit", {cpu_reset, done, error, rx_ready}, 4'b1010);
        do_restart();

        model_frame(z_ok);
        send_bytes(z_ok, 0);
        check_end("zero_ok");
        do_restart();

        model_frame(z_bad);
        send_bytes(z_bad, 0);
        check_end("zero_bad");
        chk("zero_bad_lit", error, 1'b1);
        do_restart();

        model_frame(big);
        send_bytes(big, 0);
        check_end("oversize");
        chk("oversize_lit", {error, rx_ready}, 2'b10);
        do_restart();

        model_frame(nom);
        send_bytes(nom, 3);
        check_end("gapped");
        do_restart();

        model_frame(rs);
        chk("model_rs_w0", exp_q[0], {32'h0, 32'hAABB_CCDD});
        send_bytes(rs, 0);
        check_end("after_restart");
        chk("after_restart_lit", done, 1'b1);
        do_restart();

        // Partial frame: 3 data bytes, so no write may appear before reset hits.
        send_bytes(part, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_ready",   rx_ready,   1'b0);
        chk("mid_rst_imem_we",    imem_we,    1'b0);
        chk("mid_rst_imem_addr",  imem_addr,  32'h0);
        chk("mid_rst_imem_wdata", imem_wdata, 32'h0);
        chk("mid_rst_cpu_reset",  cpu_reset,  1'b1);
        chk("mid_rst_done",       done,       1'b0);
        chk("mid_rst_error",      error,      1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_frame(nom);
        send_bytes(nom, 0);
        check_end("post_reset");
        chk("post_reset_lit", {cpu_reset, done}, 2'b01);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
